// File: rtl/db_scan_ctrl.sv
// db_scan_ctrl
// Drives the Hit comparison engine from the database side. Words arrive from
// the DDR read stream into a one-entry prefetch buffer, are moved into the
// engine with a load strobe and then walked through every position with shift
// strobes. Each engine hit becomes one result record on a valid/ready port.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             scan request, honoured only while idle
//   dbWordCount       number of words in the scan, captured with start
//   busy, done        scan in progress / one-cycle completion pulse
//   ddrData/Valid/Ready  database word stream (transfer = ddrValid & ddrReady)
//   dataBase, dataBaseValid  word presented to the engine / word loaded
//   load, shift       one-cycle engine strobes (position 0 / positions 1..N-1)
//   hit, locationQ    engine response, valid the cycle after a strobe
//   resValid/Ready    result handshake; resWord/resShift/resLoc are the record
//   hitCount          hits handed over in the current or last scan
//   dbgState          current controller state
//
// Handshake rule for both streams: a transfer happens on a rising edge where
// valid and ready are both high; the producer holds valid and its payload
// unchanged until that edge, and ready may not depend on valid.
module db_scan_ctrl #(
    parameter int DATA_W          = 512,
    parameter int SHIFT_W         = 9,
    parameter int SHIFTS_PER_WORD = 512,
    parameter int CNT_W           = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   dbWordCount,
    output logic               busy,
    output logic               done,
    input  logic [DATA_W-1:0]  ddrData,
    input  logic               ddrValid,
    output logic               ddrReady,
    output logic [DATA_W-1:0]  dataBase,
    output logic               dataBaseValid,
    output logic               load,
    output logic               shift,
    input  logic               hit,
    input  logic [SHIFT_W-1:0] locationQ,
    output logic               resValid,
    input  logic               resReady,
    output logic [CNT_W-1:0]   resWord,
    output logic [SHIFT_W-1:0] resShift,
    output logic [SHIFT_W-1:0] resLoc,
    output logic [CNT_W-1:0]   hitCount,
    output logic [2:0]         dbgState
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_STROBE = 3'd2,
        S_EVAL   = 3'd3,
        S_REPORT = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam logic [SHIFT_W-1:0] LAST_POS = SHIFT_W'(SHIFTS_PER_WORD - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    fetched_q;
    logic [CNT_W-1:0]    word_idx_q;
    logic [SHIFT_W-1:0]  pos_q;
    logic [DATA_W-1:0]   hold_q;
    logic                full_q;
    logic [DATA_W-1:0]   db_q;
    logic                db_valid_q;
    logic [CNT_W-1:0]    res_word_q;
    logic [SHIFT_W-1:0]  res_shift_q;
    logic [SHIFT_W-1:0]  res_loc_q;
    logic [CNT_W-1:0]    hit_cnt_q;

    logic                last_pos;
    logic                more_words;
    logic [CNT_W:0]      next_idx;
    logic                ddr_xfer;
    logic                advance;
    state_t              adv_state;

    assign last_pos   = (pos_q == LAST_POS);
    // One extra bit so a count near 2^CNT_W cannot wrap the comparison.
    assign next_idx   = {1'b0, word_idx_q} + {{CNT_W{1'b0}}, 1'b1};
    assign more_words = (next_idx < {1'b0, count_q});
    // Where the scan goes once the current position is finished with.
    assign adv_state  = !last_pos ? S_STROBE : (more_words ? S_FETCH : S_FINISH);
    assign advance    = ((state_q == S_EVAL) && !hit) || ((state_q == S_REPORT) && resReady);

    assign busy     = (state_q != S_IDLE);
    assign ddrReady = busy && !full_q && (fetched_q < count_q);
    assign ddr_xfer = ddrValid && ddrReady;

    assign dataBase      = db_q;
    assign dataBaseValid = db_valid_q;
    assign resWord       = res_word_q;
    assign resShift      = res_shift_q;
    assign resLoc        = res_loc_q;
    assign hitCount      = hit_cnt_q;
    assign dbgState      = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift    = 1'b0;
        resValid = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // An empty scan passes through here once, so its done pulse
                // lands two cycles after the accepted start.
                if (count_q == '0) begin
                    state_d = S_FINISH;
                end else if (full_q) begin
                    state_d = S_STROBE;
                end
            end
            S_STROBE: begin
                load    = (pos_q == '0);
                shift   = (pos_q != '0);
                state_d = S_EVAL;
            end
            S_EVAL: begin
                state_d = hit ? S_REPORT : adv_state;
            end
            S_REPORT: begin
                resValid = 1'b1;
                if (resReady) begin
                    state_d = adv_state;
                end
            end
            S_FINISH: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= '0;
            fetched_q   <= '0;
            word_idx_q  <= '0;
            pos_q       <= '0;
            hold_q      <= '0;
            full_q      <= 1'b0;
            db_q        <= '0;
            db_valid_q  <= 1'b0;
            res_word_q  <= '0;
            res_shift_q <= '0;
            res_loc_q   <= '0;
            hit_cnt_q   <= '0;
        end else begin
            if ((state_q == S_IDLE) && start) begin
                count_q    <= dbWordCount;
                fetched_q  <= '0;
                word_idx_q <= '0;
                pos_q      <= '0;
                hit_cnt_q  <= '0;
                full_q     <= 1'b0;
            end
            if (ddr_xfer) begin
                hold_q    <= ddrData;
                full_q    <= 1'b1;
                fetched_q <= fetched_q + 1'b1;
            end
            // ddrReady is low while full, so this never collides with a transfer.
            if ((state_q == S_FETCH) && full_q && (count_q != '0)) begin
                db_q       <= hold_q;
                full_q     <= 1'b0;
                pos_q      <= '0;
                db_valid_q <= 1'b1;
            end
            if ((state_q == S_EVAL) && hit) begin
                res_word_q  <= word_idx_q;
                res_shift_q <= pos_q;
                res_loc_q   <= locationQ;
            end
            if ((state_q == S_REPORT) && resReady) begin
                hit_cnt_q <= hit_cnt_q + 1'b1;
            end
            if (advance) begin
                if (!last_pos) begin
                    pos_q <= pos_q + 1'b1;
                end else begin
                    db_valid_q <= 1'b0;
                    if (more_words) begin
                        word_idx_q <= word_idx_q + 1'b1;
                    end
                end
            end
            if (state_q == S_IDLE) begin
                db_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_db_scan_ctrl.sv
module tb_db_scan_ctrl;

  localparam int DW = 64;
  localparam int SW = 9;
  localparam int N  = 4;
  localparam int CW = 32;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start = 1'b0;
  logic [CW-1:0] dbWordCount = '0;
  logic          busy, done;
  logic [DW-1:0] ddrData = '0;
  logic          ddrValid = 1'b0;
  logic          ddrReady;
  logic [DW-1:0] dataBase;
  logic          dataBaseValid, load, shift;
  logic          hit = 1'b0;
  logic [SW-1:0] locationQ = '0;
  logic          resValid;
  logic          resReady = 1'b0;
  logic [CW-1:0] resWord;
  logic [SW-1:0] resShift, resLoc;
  logic [CW-1:0] hitCount;
  logic [2:0]    dbgState;

  db_scan_ctrl #(.DATA_W(DW), .SHIFT_W(SW), .SHIFTS_PER_WORD(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .dbWordCount(dbWordCount),
    .busy(busy), .done(done), .ddrData(ddrData), .ddrValid(ddrValid), .ddrReady(ddrReady),
    .dataBase(dataBase), .dataBaseValid(dataBaseValid), .load(load), .shift(shift),
    .hit(hit), .locationQ(locationQ), .resValid(resValid), .resReady(resReady),
    .resWord(resWord), .resShift(resShift), .resLoc(resLoc), .hitCount(hitCount),
    .dbgState(dbgState)
  );

  wire [DW+2*CW+2*SW+6:0] all_outs = {busy, done, ddrReady, dataBaseValid, load, shift, resValid,
                                     dataBase, resWord, resShift, resLoc, hitCount};

  // scoreboard
  logic [CW+2*SW-1:0] exp_q[$];
  logic [DW-1:0]      db_exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // engine model / monitor state
  int hit_mode = 0;   // 0 never, 1 word1/pos2 loc 5, 2 every position
  int rr_mode  = 0;   // 0 always ready, 1 stall 5 cycles per record, 2 never
  int m_word, m_pos, loads_seen, shifts_seen, n_rec, stall_cnt;
  int first_load_cyc, first_xfer_cyc, strobe_due;
  logic pend_hit = 1'b0;
  logic [SW-1:0] pend_loc = '0;
  logic prev_stalled = 1'b0;
  logic [CW+2*SW-1:0] prev_rec = '0;

  // engine response appears during the cycle after the strobe
  always @(posedge clk) begin
    #1;
    hit = pend_hit;
    locationQ = pend_hit ? pend_loc : '0;
    pend_hit = 1'b0;
  end

  always @(negedge clk) begin
    logic h;
    logic [SW-1:0] loc;
    logic [CW+2*SW-1:0] cur, exp;
    logic [DW-1:0] db_exp;
    // result consumer first, so the monitor sees the ready it will present
    case (rr_mode)
      0: resReady = 1'b1;
      1: begin
        if (resValid && !resReady) begin
          stall_cnt++;
          if (stall_cnt > 5) resReady = 1'b1;
        end else begin
          resReady = 1'b0;
          stall_cnt = 0;
        end
      end
      default: resReady = 1'b0;
    endcase

    if (load && shift) begin
      n_vec++; n_err++;
      $display("FAIL strobe_overlap: load=%b shift=%b, required not both high", load, shift);
    end
    if ((load || shift) && resValid) begin
      n_vec++; n_err++;
      $display("FAIL strobe_during_result: load=%b shift=%b resValid=1, required no strobe", load, shift);
    end
    if (strobe_due == cyc) begin
      n_vec++;
      if (!(load || shift)) begin
        n_err++;
        $display("FAIL strobe_after_result: no strobe at cycle %0d, required one", cyc);
      end
      strobe_due = -1;
    end

    if (load) begin
      loads_seen++; m_word++; m_pos = 0;
      if (first_load_cyc < 0) first_load_cyc = cyc;
      n_vec++;
      if (db_exp_q.size() == 0) begin
        n_err++;
        $display("FAIL load_without_data: dataBase=%h, required an accepted ddr word first", dataBase);
      end else begin
        db_exp = db_exp_q.pop_front();
        if (dataBase !== db_exp || dataBaseValid !== 1'b1) begin
          n_err++;
          $display("FAIL load_word: dataBase=%h valid=%b, required %h valid=1", dataBase, dataBaseValid, db_exp);
        end
      end
    end else if (shift) begin
      shifts_seen++; m_pos++;
    end

    if (load || shift) begin
      h = 1'b0; loc = '0;
      case (hit_mode)
        1: begin h = (m_word == 1 && m_pos == 2); loc = 9'h05; end
        2: begin h = 1'b1; loc = SW'($urandom_range(0, 511)); end
        default: h = 1'b0;
      endcase
      pend_hit = h;
      pend_loc = loc;
      if (h) exp_q.push_back({CW'(m_word), SW'(m_pos), loc});
    end

    cur = {resWord, resShift, resLoc};
    if (resValid) begin
      if (prev_stalled) begin
        n_vec++;
        if (cur !== prev_rec) begin
          n_err++;
          $display("FAIL record_stable: record=%h, required %h while stalled", cur, prev_rec);
        end
      end
      if (resReady) begin
        n_vec++; n_rec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_record: record=%h, required none", cur);
        end else begin
          exp = exp_q.pop_front();
          if (cur !== exp) begin
            n_err++;
            $display("FAIL record: word/shift/loc=%0d/%0d/%0d, required %0d/%0d/%0d",
                     resWord, resShift, resLoc, exp[CW+2*SW-1:2*SW], exp[2*SW-1:SW], exp[SW-1:0]);
          end
        end
        if (m_pos < N - 1) strobe_due = cyc + 1;
      end
    end
    prev_stalled = resValid && !resReady;
    prev_rec = cur;
  end

  // driver tasks
  task automatic clear_model();
    exp_q.delete(); db_exp_q.delete();
    m_word = -1; m_pos = 0; loads_seen = 0; shifts_seen = 0; n_rec = 0; stall_cnt = 0;
    first_load_cyc = -1; first_xfer_cyc = -1; strobe_due = -1;
    pend_hit = 1'b0;
  endtask

  task automatic start_scan(input int count);
    @(negedge clk);
    dbWordCount = CW'(count);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || ddrReady !== (count != 0)) begin
      n_err++;
      $display("FAIL start_response: busy=%b ddrReady=%b, required 1/%b", busy, ddrReady, count != 0);
    end
  endtask

  task automatic feed_ddr(input int nwords, input int gap);
    for (int i = 0; i < nwords; i++) begin
      bit ok;
      repeat (gap) @(negedge clk);
      ddrValid = 1'b1;
      ddrData = {$urandom, $urandom};
      ok = 0;
      for (int t = 0; t < 400 && !ok; t++) begin
        if (ddrReady) begin
          ok = 1;
          db_exp_q.push_back(ddrData);
          if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
        end
        @(negedge clk);
      end
      ddrValid = 1'b0;
      if (!ok) begin
        n_vec++; n_err++;
        $display("FAIL ddr_accept_timeout: word %0d never accepted, required acceptance", i);
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL done_timeout: no done within %0d cycles, required a done pulse", budget);
    end else begin
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_err++;
        $display("FAIL after_done: busy=%b done=%b, required 0/0", busy, done);
      end
    end
  endtask

  task automatic run_scan(input int count, input int gap);
    start_scan(count);
    fork
      feed_ddr(count, gap);
      wait_done(3000);
    join
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: outputs=%h, required all zero", all_outs);
    end
  endtask

  task automatic test_zero_count();
    clear_model();
    start_scan(0);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done_early: done=%b at T+1, required 0", done);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b1 || ddrReady !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done: done=%b ddrReady=%b at T+2, required 1/0", done, ddrReady);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || loads_seen != 0 || ddrReady !== 1'b0) begin
      n_err++;
      $display("FAIL zero_end: busy=%b done=%b loads=%0d ddrReady=%b, required 0/0/0/0", busy, done, loads_seen, ddrReady);
    end
  endtask

  task automatic test_no_hit();
    bit seen_ready;
    clear_model();
    hit_mode = 0; rr_mode = 0;
    run_scan(2, 0);
    n_vec++;
    if (loads_seen != 2 || shifts_seen != 6 || hitCount !== '0 || n_rec != 0) begin
      n_err++;
      $display("FAIL no_hit_counts: loads=%0d shifts=%0d hitCount=%0d records=%0d, required 2/6/0/0",
               loads_seen, shifts_seen, hitCount, n_rec);
    end
    n_vec++;
    if (first_load_cyc != first_xfer_cyc + 2) begin
      n_err++;
      $display("FAIL load_latency: load at %0d, required %0d", first_load_cyc, first_xfer_cyc + 2);
    end
    // surplus word on the stream must be left alone
    ddrValid = 1'b1;
    seen_ready = 0;
    repeat (5) begin
      @(negedge clk);
      if (ddrReady) seen_ready = 1;
    end
    ddrValid = 1'b0;
    n_vec++;
    if (seen_ready) begin
      n_err++;
      $display("FAIL extra_word: ddrReady=1 after scan, required 0");
    end
  endtask

  task automatic test_single_hit();
    clear_model();
    hit_mode = 1; rr_mode = 0;
    run_scan(3, 0);
    n_vec++;
    if (n_rec != 1 || hitCount !== 1 || exp_q.size() != 0 || loads_seen != 3 || shifts_seen != 9) begin
      n_err++;
      $display("FAIL single_hit: records=%0d hitCount=%0d pending=%0d loads=%0d shifts=%0d, required 1/1/0/3/9",
               n_rec, hitCount, exp_q.size(), loads_seen, shifts_seen);
    end
  endtask

  task automatic test_hit_every_position();
    clear_model();
    hit_mode = 2; rr_mode = 1;
    run_scan(1, 0);
    n_vec++;
    if (n_rec != 4 || hitCount !== 4 || exp_q.size() != 0 || loads_seen != 1 || shifts_seen != 3) begin
      n_err++;
      $display("FAIL every_hit: records=%0d hitCount=%0d pending=%0d loads=%0d shifts=%0d, required 4/4/0/1/3",
               n_rec, hitCount, exp_q.size(), loads_seen, shifts_seen);
    end
  endtask

  task automatic test_ddr_throttle();
    clear_model();
    hit_mode = 0; rr_mode = 0;
    run_scan(2, 6);
    n_vec++;
    if (loads_seen != 2 || shifts_seen != 6 || db_exp_q.size() != 0) begin
      n_err++;
      $display("FAIL throttle_counts: loads=%0d shifts=%0d unused_words=%0d, required 2/6/0",
               loads_seen, shifts_seen, db_exp_q.size());
    end
    n_vec++;
    if (first_load_cyc != first_xfer_cyc + 2) begin
      n_err++;
      $display("FAIL throttle_latency: load at %0d, required %0d", first_load_cyc, first_xfer_cyc + 2);
    end
  endtask

  task automatic test_reset_mid_scan();
    int k;
    clear_model();
    hit_mode = 2; rr_mode = 2;
    start_scan(1);
    feed_ddr(1, 0);
    k = 0;
    while (resValid !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (resValid !== 1'b1) begin
      n_err++;
      $display("FAIL report_timeout: resValid=%b, required 1 within 50 cycles", resValid);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (all_outs !== '0) begin
      n_err++;
      $display("FAIL reset_mid_scan: outputs=%h, required all zero", all_outs);
    end
    // the record in flight is gone; a fresh scan must run cleanly
    clear_model();
    hit_mode = 0; rr_mode = 0;
    run_scan(1, 0);
    n_vec++;
    if (loads_seen != 1 || shifts_seen != 3 || hitCount !== '0 || n_rec != 0) begin
      n_err++;
      $display("FAIL rescan: loads=%0d shifts=%0d hitCount=%0d records=%0d, required 1/3/0/0",
               loads_seen, shifts_seen, hitCount, n_rec);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_zero_count();
    test_no_hit();
    test_single_hit();
    test_hit_every_position();
    test_ddr_throttle();
    test_reset_mid_scan();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
